// File: rtl/jump_target_unit.sv
// jump_target_unit: next-PC calculator for JUMP/BRANCH/JR/CALL/RET with a return-address stack.
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset
//   start    - request, sampled only in IDLE
//   mode     - 0 JUMP, 1 BRANCH, 2 JR, 3 CALL, 4 RET, 5-7 illegal
//   pc       - current PC
//   imm      - instruction immediate
//   regAddr  - register operand for JR
//   busy     - high in CALC and DONE
//   done     - one-cycle completion pulse
//   target   - computed next PC, held until the next done
//   error    - qualifies done: illegal mode, RAS overflow or underflow
//   rasEmpty - stack holds no entries
//   rasFull  - stack holds RAS_DEPTH entries
module jump_target_unit #(
    parameter int ADDR_W    = 16,
    parameter int IMM_W     = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm,
    input  logic [ADDR_W-1:0] regAddr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] target,
    output logic              error,
    output logic              rasEmpty,
    output logic              rasFull
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    state_t            state_q;
    logic [2:0]        mode_q;
    logic [ADDR_W-1:0] pc_q;
    logic [IMM_W-1:0]  imm_q;
    logic [ADDR_W-1:0] reg_q;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              error_q, error_d;
    logic              busy_q, done_q, empty_q, full_q;
    logic              push_d;
    logic [ADDR_W-1:0] pc_inc, jump_tgt, branch_tgt;
    logic [IDX_W-1:0]  top_idx;
    logic              is_empty, is_full;
    always_comb begin
        pc_inc     = pc_q + ADDR_W'(1);
        jump_tgt   = {pc_q[ADDR_W-1:IMM_W], imm_q};
        branch_tgt = pc_q + {{(ADDR_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
        is_empty   = ptr_q == '0;
        is_full    = ptr_q == PTR_W'(RAS_DEPTH);
        // entry below the pointer; wraps correctly when the stack is full
        top_idx    = ptr_q[IDX_W-1:0] - IDX_W'(1);
        target_d   = pc_inc;
        error_d    = 1'b1;
        ptr_d      = ptr_q;
        push_d     = 1'b0;
        case (mode_q)
            3'd0: begin
                target_d = jump_tgt;
                error_d  = 1'b0;
            end
            3'd1: begin
                target_d = branch_tgt;
                error_d  = 1'b0;
            end
            3'd2: begin
                target_d = reg_q;
                error_d  = 1'b0;
            end
            3'd3: begin
                target_d = jump_tgt;
                error_d  = is_full;
                push_d   = !is_full;
                ptr_d    = is_full ? ptr_q : ptr_q + PTR_W'(1);
            end
            3'd4: begin
                target_d = is_empty ? pc_inc : ras_q[top_idx];
                error_d  = is_empty;
                ptr_d    = is_empty ? ptr_q : ptr_q - PTR_W'(1);
            end
            default: ;
        endcase
    end
    // stack storage is not reset; only the pointer defines validity
    always_ff @(posedge clk) begin
        if (!reset && state_q == CALC && push_d)
            ras_q[ptr_q[IDX_W-1:0]] <= pc_inc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            target_q <= '0;
            ptr_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        pc_q    <= pc;
                        imm_q   <= imm;
                        reg_q   <= regAddr;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    target_q <= target_d;
                    error_q  <= error_d;
                    ptr_q    <= ptr_d;
                    empty_q  <= ptr_d == '0;
                    full_q   <= ptr_d == PTR_W'(RAS_DEPTH);
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign target   = target_q;
    assign error    = error_q;
    assign rasEmpty = empty_q;
    assign rasFull  = full_q;
endmodule

// File: tb/tb_jump_target_unit.sv
// tb_jump_target_unit: directed self-checking bench for jump_target_unit.
module tb_jump_target_unit;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  mode;
    logic [15:0] pc, regAddr, target;
    logic [11:0] imm;
    logic        busy, done, error, rasEmpty, rasFull;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_done;

    jump_target_unit dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .pc(pc),
        .imm(imm), .regAddr(regAddr), .busy(busy), .done(done),
        .target(target), .error(error), .rasEmpty(rasEmpty), .rasFull(rasFull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // issue one op from IDLE (called just after a negedge), scramble inputs after capture
    task automatic op(input string tag, input logic [2:0] m, input logic [15:0] p,
                      input logic [11:0] i, input logic [15:0] r,
                      input logic [15:0] et, input logic ee);
        mode = m; pc = p; imm = i; regAddr = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 3'd5; pc = 16'hFFFF; imm = 12'hFFF; regAddr = 16'h5A5A;
        chk({tag, "_calc_done"}, done, 0);
        chk({tag, "_calc_busy"}, busy, 1);
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_target"}, target, et);
        chk({tag, "_error"}, error, ee);
        @(negedge clk);
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_held"}, target, et);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = '0; pc = '0; imm = '0; regAddr = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_target", target, 0);
        chk("rst_error", error, 0);
        chk("rst_empty", rasEmpty, 1);
        chk("rst_full", rasFull, 0);
        @(negedge clk);
        op("jump", 3'd0, 16'h3456, 12'hABC, 16'h0, 16'h3ABC, 1'b0);
        op("br_neg", 3'd1, 16'h0010, 12'hFFE, 16'h0, 16'h000E, 1'b0);
        op("br_wrap", 3'd1, 16'hFFFF, 12'h001, 16'h0, 16'h0000, 1'b0);
        op("jr", 3'd2, 16'h1234, 12'h000, 16'hBEEF, 16'hBEEF, 1'b0);
        op("call1", 3'd3, 16'h0100, 12'h500, 16'h0, 16'h0500, 1'b0);
        chk("call1_empty", rasEmpty, 0);
        op("call2", 3'd3, 16'h0200, 12'h500, 16'h0, 16'h0500, 1'b0);
        op("call3", 3'd3, 16'h0300, 12'h500, 16'h0, 16'h0500, 1'b0);
        chk("call3_full", rasFull, 0);
        op("call4", 3'd3, 16'h0400, 12'h500, 16'h0, 16'h0500, 1'b0);
        chk("call4_full", rasFull, 1);
        op("call5", 3'd3, 16'h9900, 12'h123, 16'h0, 16'h9123, 1'b1);
        chk("call5_full", rasFull, 1);
        op("ret1", 3'd4, 16'h7777, 12'h000, 16'h0, 16'h0401, 1'b0);
        chk("ret1_full", rasFull, 0);
        op("ret2", 3'd4, 16'h7777, 12'h000, 16'h0, 16'h0301, 1'b0);
        op("ret3", 3'd4, 16'h7777, 12'h000, 16'h0, 16'h0201, 1'b0);
        op("ret4", 3'd4, 16'h7777, 12'h000, 16'h0, 16'h0101, 1'b0);
        chk("ret4_empty", rasEmpty, 1);
        op("ret_empty", 3'd4, 16'h0050, 12'h000, 16'h0, 16'h0051, 1'b1);
        chk("ret_empty_empty", rasEmpty, 1);
        op("mode6", 3'd6, 16'h1234, 12'h000, 16'h0, 16'h1235, 1'b1);
        op("err_clear", 3'd0, 16'h0000, 12'h001, 16'h0, 16'h0001, 1'b0);
        // start held high through CALC and DONE with changing inputs
        n_done = 0;
        mode = 3'd0; pc = 16'h1000; imm = 12'h111; start = 1'b1;
        @(negedge clk);
        mode = 3'd2; pc = 16'h2000; regAddr = 16'hDEAD;
        @(negedge clk);
        n_done += int'(done);
        chk("hold_target", target, 16'h1111);
        @(negedge clk);
        n_done += int'(done);
        chk("hold_busy", busy, 0);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_done += int'(done);
        end
        chk("hold_ndone", n_done, 1);
        chk("hold_target_kept", target, 16'h1111);
        // reset in CALC of a CALL with one entry already on the stack
        op("pre_call", 3'd3, 16'h0600, 12'h222, 16'h0, 16'h0222, 1'b0);
        mode = 3'd3; pc = 16'h0700; imm = 12'h333; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rstcalc_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstcalc_done", done, 0);
        chk("rstcalc_busy", busy, 0);
        chk("rstcalc_target", target, 0);
        chk("rstcalc_empty", rasEmpty, 1);
        n_done = 0;
        repeat (3) begin
            @(negedge clk);
            n_done += int'(done);
        end
        chk("rstcalc_nodone", n_done, 0);
        op("post_rst_ret", 3'd4, 16'h0080, 12'h000, 16'h0, 16'h0081, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jump_target_unit.md
JUMP_TARGET_UNIT -- requirements
Module: jump_target_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have the following parameters:
- ADDR_W, default 16, address width.
- IMM_W, default 12, immediate width; IMM_W < ADDR_W.
- RAS_DEPTH, default 4, return-address-stack entries; power of 2, at least 2.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, request; sampled only in IDLE.
- mode, in, 3, operation select.
- pc, in, ADDR_W, current PC.
- imm, in, IMM_W, instruction immediate field.
- regAddr, in, ADDR_W, register operand for JR.
- busy, out, 1, high in CALC and DONE.
- done, out, 1, one-cycle completion pulse.
- target, out, ADDR_W, computed next PC; held until the next done.
- error, out, 1, qualifies done; illegal mode, RAS overflow or RAS underflow.
- rasEmpty, out, 1, stack holds 0 entries.
- rasFull, out, 1, stack holds RAS_DEPTH entries.

Function
REQ-004 The FSM SHALL have states IDLE, CALC and DONE; IDLE->CALC on start; CALC->DONE always; DONE->IDLE always.
REQ-005 In IDLE with start=1, the block SHALL capture mode, pc, imm and regAddr into internal registers; later input changes SHALL NOT affect the result.
REQ-006 start SHALL be ignored in CALC and DONE; no queuing.
REQ-007 done SHALL be high for exactly the DONE cycle, 2 cycles after the start cycle; target and error SHALL update on the same edge done rises.
REQ-008 mode 0 (JUMP): target SHALL be {pc[ADDR_W-1:IMM_W], imm}.
REQ-009 mode 1 (BRANCH): target SHALL be pc + sign_extend(imm), modulo 2^ADDR_W.
REQ-010 mode 2 (JR): target SHALL be regAddr.
REQ-011 mode 3 (CALL): target SHALL be as JUMP, and pc+1 (mod 2^ADDR_W) SHALL be pushed onto the RAS.
REQ-012 mode 4 (RET): target SHALL be the top RAS entry, which is popped.
REQ-013 The RAS SHALL be LIFO with a pointer that counts 0..RAS_DEPTH; push and pop SHALL occur only on the CALC->DONE edge.
REQ-014 A CALL with rasFull=1 SHALL still produce the JUMP target, SHALL NOT push or modify the stack, and SHALL set error=1.
REQ-015 A RET with rasEmpty=1 SHALL produce target = pc+1, SHALL NOT change the pointer, and SHALL set error=1.
REQ-016 Modes 5-7 SHALL produce target = pc+1 with error=1 and no RAS change.
REQ-017 error SHALL be 0 for any legal, non-overflowing operation.
REQ-018 rasEmpty and rasFull SHALL be registered and reflect the pointer after each update.

Reset
REQ-019 On reset=1 at a clock edge, the following SHALL take effect regardless of FSM state, including mid-operation:
- state SHALL go to IDLE.
- busy=0, done=0, error=0, target=0.
- the RAS pointer SHALL be 0, so rasEmpty=1 and rasFull=0.
REQ-020 An operation interrupted by reset SHALL NOT produce a done and SHALL NOT modify the RAS.
REQ-021 RAS entry contents need not be cleared by reset.

Verification
REQ-022 The bench SHALL cover the following directed scenarios (defaults):
- JUMP: pc=0x3456, imm=0xABC -> target=0x3ABC, error=0, done pulse 2 cycles after start.
- BRANCH: pc=0x0010, imm=0xFFE (-2) -> 0x000E; pc=0xFFFF, imm=0x001 -> 0x0000 (wrap).
- CALL x4 from pc=0x0100,0x0200,0x0300,0x0400 -> rasFull=1; 5th CALL -> error=1 with stack unchanged; RET x4 -> targets 0x0401,0x0301,0x0201,0x0101; then rasEmpty=1.
- RET with empty stack, pc=0x0050 -> target=0x0051, error=1; mode=6 -> error=1.
- start held high while busy -> exactly one done per IDLE acceptance; input changes after the start cycle do not alter target.
- reset asserted in CALC of a CALL -> no done, rasEmpty=1, target=0 next cycle.
